// File: rtl/lap_record_scheduler.sv
// lap_record_scheduler
//
// Buffers lap timestamps captured from the stopwatch datapath and hands them
// to the LCD bridge one at a time, obeying the bridge's insert/busy handshake.
// A clear request flushes the queue at once. The matching LCD clear is only
// sent after any transaction already in flight has finished, so the bridge
// never sees more than one outstanding command.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high; wins over every other input
//   capture      one-cycle pulse, latch record_in into the queue
//   record_in    flat BCD timestamp sampled on capture
//   clear_req    one-cycle pulse, flush queue and clear the LCD
//   lcd_busy     busy from lcd_bridge
//   lcd_insert   one-cycle insert pulse to lcd_bridge
//   lcd_record   record presented to lcd_bridge, held until the next pop
//   lcd_clear    one-cycle clear pulse to lcd_bridge
//   count        entries currently queued
//   full         count == DEPTH
//   empty        count == 0
//   overflow     sticky, a capture was dropped because the queue was full
//   timeout_err  sticky, busy never rose within ACK_TIMEOUT cycles
//
// Timing of a pop: the head is copied into lcd_record at the edge that raises
// lcd_insert. The read pointer and count advance at the following edge, i.e.
// the cycle in which lcd_insert is high is the "pop cycle". A capture into a
// full queue during that cycle is accepted: it overwrites the slot that was
// just copied out.

module lap_record_scheduler #(
    parameter int DEPTH       = 8,
    parameter int WIDTH       = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     capture,
    input  logic [WIDTH-1:0]         record_in,
    input  logic                     clear_req,
    input  logic                     lcd_busy,
    output logic                     lcd_insert,
    output logic [WIDTH-1:0]         lcd_record,
    output logic                     lcd_clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLR_ISSUE = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_WAIT_FALL = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nx_s;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;

    logic             clear_pending_r;
    logic             lcd_insert_r;
    logic             lcd_clear_r;
    logic [WIDTH-1:0] lcd_record_r;
    logic             timeout_r;
    logic [TW-1:0]    timer_r;

    logic             pop_s;
    logic             wr_en_s;
    logic             drop_s;
    logic             issue_ins_s;
    logic             issue_clr_s;
    logic             timeout_hit_s;

    // Handshake decisions: when to start an insert or a clear, and when the
    // wait for busy has run out.
    always_comb begin
        pop_s         = lcd_insert_r;
        issue_ins_s   = 1'b0;
        issue_clr_s   = 1'b0;
        timeout_hit_s = 1'b0;
        if (state_r == ST_IDLE) begin
            issue_clr_s = clear_pending_r;
            // A clear arriving in this very cycle flushes the head, so the
            // insert must not go out with a record that no longer exists.
            issue_ins_s = !clear_pending_r && !clear_req && !empty_r && !lcd_busy;
        end else begin
            issue_clr_s = 1'b0;
            issue_ins_s = 1'b0;
        end
        if ((state_r == ST_WAIT_RISE) && !lcd_busy &&
            (timer_r == TW'(ACK_TIMEOUT - 1))) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Queue write/drop decisions and next occupancy.
    always_comb begin
        wr_en_s    = 1'b0;
        drop_s     = 1'b0;
        count_nx_s = count_r;
        // A capture in the same cycle as a clear is discarded silently.
        if (capture && !clear_req) begin
            if (!full_r || pop_s) begin
                wr_en_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
            drop_s  = 1'b0;
        end
        if (clear_req) begin
            count_nx_s = {CW{1'b0}};
        end else begin
            case ({wr_en_s, pop_s})
                2'b10:   count_nx_s = count_r + CW'(1);
                2'b01:   count_nx_s = count_r - CW'(1);
                default: count_nx_s = count_r;
            endcase
        end
    end

    // Next-state logic of the bridge sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_clr_s) begin
                    state_nx_s = ST_CLR_ISSUE;
                end else if (issue_ins_s) begin
                    state_nx_s = ST_WAIT_RISE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CLR_ISSUE: begin
                state_nx_s = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (lcd_busy) begin
                    state_nx_s = ST_WAIT_FALL;
                end else if (timeout_hit_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_RISE;
                end
            end
            ST_WAIT_FALL: begin
                if (!lcd_busy) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_FALL;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Record storage; contents need no reset because empty slots are never read.
    always_ff @(posedge clock) begin
        if (!reset && wr_en_s) begin
            mem_r[wr_ptr_r] <= record_in;
        end
    end

    // Queue pointers, occupancy flags and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (clear_req) begin
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
            end else begin
                // DEPTH is a power of two, so pointer wrap is free.
                if (wr_en_s) begin
                    wr_ptr_r <= wr_ptr_r + PW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end
            end
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == CW'(DEPTH));
            empty_r <= (count_nx_s == {CW{1'b0}});
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Sequencer state, registered bridge outputs, pending clear and ack timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            clear_pending_r <= 1'b0;
            lcd_insert_r    <= 1'b0;
            lcd_clear_r     <= 1'b0;
            lcd_record_r    <= {WIDTH{1'b0}};
            timeout_r       <= 1'b0;
            timer_r         <= {TW{1'b0}};
        end else begin
            state_r      <= state_nx_s;
            lcd_insert_r <= issue_ins_s;
            lcd_clear_r  <= issue_clr_s;
            if (issue_ins_s) begin
                lcd_record_r <= mem_r[rd_ptr_r];
            end
            // The clear being issued right now also covers any request that
            // lands in the same cycle, so it is absorbed rather than queued.
            if (state_r == ST_CLR_ISSUE) begin
                clear_pending_r <= 1'b0;
            end else if (clear_req) begin
                clear_pending_r <= 1'b1;
            end
            if (timeout_hit_s) begin
                timeout_r <= 1'b1;
            end
            if (state_r == ST_WAIT_RISE) begin
                timer_r <= timer_r + TW'(1);
            end else begin
                timer_r <= {TW{1'b0}};
            end
        end
    end

    assign lcd_insert  = lcd_insert_r;
    assign lcd_record  = lcd_record_r;
    assign lcd_clear   = lcd_clear_r;
    assign count       = count_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign overflow    = overflow_r;
    assign timeout_err = timeout_r;

endmodule

// File: tb/tb_lap_record_scheduler.sv
`timescale 1ns/1ps

module tb_lap_record_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        capture;
    logic [31:0] record_in;
    logic        clear_req;
    logic        lcd_busy;
    logic        lcd_insert;
    logic [31:0] lcd_record;
    logic        lcd_clear;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        timeout_err;

    logic        hold_busy;
    logic        model_busy;
    logic        bridge_en;

    typedef struct {
        bit          is_clear;
        logic [31:0] value;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    assign lcd_busy = hold_busy | model_busy;

    always #10 clock = ~clock;

    lap_record_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .capture     (capture),
        .record_in   (record_in),
        .clear_req   (clear_req),
        .lcd_busy    (lcd_busy),
        .lcd_insert  (lcd_insert),
        .lcd_record  (lcd_record),
        .lcd_clear   (lcd_clear),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push_ins(input logic [31:0] v);
        ev_t e;
        e.is_clear = 1'b0;
        e.value    = v;
        sb.push_back(e);
    endtask

    task automatic push_clr();
        ev_t e;
        e.is_clear = 1'b1;
        e.value    = 32'h0;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        capture   = 1'b0;
        clear_req = 1'b0;
        record_in = 32'h0;
        hold_busy = 1'b0;
        bridge_en = 1'b1;
        repeat (10) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && empty && !lcd_busy) break;
            tick();
        end
        repeat (20) tick();
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // Bridge model: busy rises the cycle after a command and stays up 5 cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (bridge_en && (lcd_insert || lcd_clear)) begin
                @(posedge clock);
                #1 model_busy = 1'b1;
                repeat (5) @(posedge clock);
                #1 model_busy = 1'b0;
            end
        end
    end

    // Monitor: every bridge command must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset === 1'b0 && (lcd_insert === 1'b1 || lcd_clear === 1'b1)) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_cmd: got insert=%0b clear=%0b record=%0h, expected no command",
                         lcd_insert, lcd_clear, lcd_record);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (e.is_clear) begin
                    if (lcd_clear && !lcd_insert) n_pass++;
                    else $display("FAIL cmd_clear: got insert=%0b clear=%0b, expected clear only",
                                  lcd_insert, lcd_clear);
                end else begin
                    if (lcd_insert && !lcd_clear && lcd_record === e.value) n_pass++;
                    else $display("FAIL cmd_insert: got insert=%0b clear=%0b record=%0h, expected insert of %0h",
                                  lcd_insert, lcd_clear, lcd_record, e.value);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset state and single-capture latency
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_insert", lcd_insert, 0);
        chk("rst_clear", lcd_clear, 0);
        chk("rst_record", lcd_record, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout_err, 0);
        capture   = 1'b1;
        record_in = 32'h0012_3456;
        push_ins(32'h0012_3456);
        tick();
        capture = 1'b0;
        chk("t1_count_c1", count, 1);
        chk("t1_insert_c1", lcd_insert, 0);
        tick();
        chk("t1_insert_c2", lcd_insert, 1);
        chk("t1_record_c2", lcd_record, 32'h0012_3456);
        chk("t1_count_c2", count, 1);
        tick();
        chk("t1_insert_c3", lcd_insert, 0);
        chk("t1_count_c3", count, 0);
        wait_drain("t1_drain");
        chk("t1_empty", empty, 1);
        chk("t1_record_hold", lcd_record, 32'h0012_3456);

        // Test 2: fill while busy, overflow, ordered drain
        do_reset();
        hold_busy = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            capture   = 1'b1;
            record_in = 32'(i);
            if (i <= 8) push_ins(32'(i));
            tick();
        end
        capture = 1'b0;
        chk("t2_full", full, 1);
        chk("t2_count", count, 8);
        chk("t2_overflow", overflow, 1);
        hold_busy = 1'b0;
        wait_drain("t2_drain");
        chk("t2_overflow_sticky", overflow, 1);
        chk("t2_empty", empty, 1);

        // Test 3: clear during WAIT_FALL of the first insert
        do_reset();
        push_ins(32'h11);
        for (int i = 0; i < 3; i++) begin
            capture   = 1'b1;
            record_in = 32'h11 * 32'(i + 1);
            tick();
        end
        capture = 1'b0;
        chk("t3_busy_c3", lcd_busy, 1);
        tick();
        chk("t3_count_c4", count, 2);
        clear_req = 1'b1;
        push_clr();
        tick();
        clear_req = 1'b0;
        chk("t3_count_after_clr", count, 0);
        chk("t3_empty_after_clr", empty, 1);
        chk("t3_no_early_clear", lcd_clear, 0);
        wait_drain("t3_drain");

        // Test 4: capture with clear, second clear two cycles later
        do_reset();
        capture   = 1'b1;
        record_in = 32'h44;
        clear_req = 1'b1;
        push_clr();
        tick();
        capture   = 1'b0;
        clear_req = 1'b0;
        chk("t4_count", count, 0);
        chk("t4_overflow", overflow, 0);
        chk("t4_empty", empty, 1);
        tick();
        chk("t4_clear_pulse", lcd_clear, 1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_drain("t4_drain");
        chk("t4_overflow_end", overflow, 0);
        chk("t4_count_end", count, 0);

        // Test 5: bridge never answers, timeout then next record
        do_reset();
        bridge_en = 1'b0;
        capture   = 1'b1;
        record_in = 32'h55;
        push_ins(32'h55);
        tick();
        record_in = 32'h66;
        push_ins(32'h66);
        tick();
        capture = 1'b0;
        chk("t5_insert_x", lcd_insert, 1);
        chk("t5_record_x", lcd_record, 32'h55);
        repeat (15) tick();
        chk("t5_timeout_c17", timeout_err, 0);
        tick();
        chk("t5_timeout_c18", timeout_err, 1);
        chk("t5_insert_c18", lcd_insert, 0);
        tick();
        chk("t5_insert_y", lcd_insert, 1);
        chk("t5_record_y", lcd_record, 32'h66);
        wait_drain("t5_drain");
        chk("t5_timeout_sticky", timeout_err, 1);
        bridge_en = 1'b1;

        // Test 6: capture into a full queue in the pop cycle, then reset mid-transaction
        do_reset();
        hold_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            capture   = 1'b1;
            record_in = 32'h61 + 32'(i);
            push_ins(32'h61 + 32'(i));
            tick();
        end
        capture = 1'b0;
        chk("t6_full", full, 1);
        chk("t6_count_full", count, 8);
        hold_busy = 1'b0;
        tick();
        chk("t6_pop_insert", lcd_insert, 1);
        chk("t6_pop_record", lcd_record, 32'h61);
        capture   = 1'b1;
        record_in = 32'h69;
        push_ins(32'h69);
        tick();
        capture = 1'b0;
        chk("t6_count_kept", count, 8);
        chk("t6_overflow", overflow, 0);
        chk("t6_full_kept", full, 1);
        wait_drain("t6_drain");
        chk("t6_overflow_end", overflow, 0);

        capture   = 1'b1;
        record_in = 32'h7A;
        push_ins(32'h7A);
        tick();
        capture = 1'b0;
        repeat (3) tick();
        chk("t6_busy_wait_fall", lcd_busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6r_insert", lcd_insert, 0);
        chk("t6r_clear", lcd_clear, 0);
        chk("t6r_record", lcd_record, 0);
        chk("t6r_count", count, 0);
        chk("t6r_empty", empty, 1);
        chk("t6r_full", full, 0);
        chk("t6r_overflow", overflow, 0);
        chk("t6r_timeout", timeout_err, 0);
        repeat (20) tick();
        chk("t6r_no_reissue", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lap_record_scheduler.md
Name: lap_record_scheduler

Overview:
- Buffers lap timestamps (flat BCD, 8 digits) captured from the stopwatch datapath and sequences them, one at a time, into the LCD bridge.
- Obeys the bridge's insert/busy handshake.
- Serialises clear requests against in-flight inserts, so laps pressed while the LCD is updating are queued, not lost.
- Sits between key_logic_fsm/internal timer and lcd_bridge, replacing the direct insert_value/clear_value wiring.

Parameters:
- DEPTH, 8, queue entries; power of two, 2..64.
- WIDTH, 32, record width in bits (8 BCD digits).
- ACK_TIMEOUT, 16, max cycles to wait for busy to rise after an insert/clear pulse; must be at least 2.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- capture  in  1  one-cycle pulse; latch record_in into queue
- record_in  in  WIDTH  flat BCD timestamp sampled on capture
- clear_req  in  1  one-cycle pulse; flush queue and clear LCD
- lcd_busy  in  1  busy from lcd_bridge
- lcd_insert  out  1  one-cycle insert pulse to lcd_bridge
- lcd_record  out  WIDTH  record presented to lcd_bridge
- lcd_clear  out  1  one-cycle clear pulse to lcd_bridge
- count  out  $clog2(DEPTH)+1  entries currently queued
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky; a capture was dropped
- timeout_err  out  1  sticky; busy never rose within ACK_TIMEOUT

Behaviour:
- Reset, synchronous: state=IDLE, pointers=0, count=0, empty=1, full=0, lcd_insert=0, lcd_clear=0, lcd_record=0, overflow=0, timeout_err=0. Reset wins over every input in the same cycle. Reset mid-transaction abandons it; no pulse is re-issued.
- Queue: circular FIFO, registered pointers, count updated at the edge.
  - capture when not full: write at the edge; count+1 next cycle.
  - capture when full: dropped, overflow<=1. Exception: if a pop occurs in the same cycle, the write is accepted and count is unchanged.
  - Pointers wrap modulo DEPTH.
- State machine, all outputs registered:
  - IDLE:
    - If clear_pending: go to CLR_ISSUE.
    - Else if !empty and !lcd_busy: pop the head into lcd_record, set lcd_insert=1 for exactly one cycle, go to WAIT_RISE.
  - CLR_ISSUE: lcd_clear=1 for one cycle, clear_pending<=0, go to WAIT_RISE.
  - WAIT_RISE:
    - If lcd_busy=1: go to WAIT_FALL.
    - Else after ACK_TIMEOUT cycles: timeout_err<=1, go to IDLE.
  - WAIT_FALL: when lcd_busy=0, go to IDLE.
- Latency: capture in cycle 0 with queue empty, IDLE, lcd_busy=0 gives count=1 in cycle 1 and lcd_insert=1 in cycle 2 (count back to 0 in cycle 3). lcd_record holds its value until the next pop.
- Clear:
  - clear_req sets clear_pending and flushes the queue at the same edge (pointers=0, count=0).
  - A capture in the same cycle as clear_req is discarded; overflow is not set.
  - If a transaction is in flight, it completes first, then CLR_ISSUE runs.
  - Multiple clear_req pulses before CLR_ISSUE coalesce into one lcd_clear.
  - Clear priority over insert in IDLE.
- lcd_insert and lcd_clear are never high together. Never more than one outstanding bridge transaction.
- overflow and timeout_err clear only on reset.

Test Plan:
1. Reset, then single capture of 32'h0012_3456 with lcd_busy=0 -> lcd_insert high exactly in cycle 2 with lcd_record=32'h0012_3456. Bridge model raises busy for 5 cycles -> FSM returns to IDLE; empty=1.
2. Hold lcd_busy=1, issue 9 captures (DEPTH=8) with values 1..9 -> full=1, count=8, overflow=1. Release busy -> lcd_record emits 1..8 in order, one per busy cycle; value 9 is never emitted.
3. Capture 3 records, then clear_req during WAIT_FALL of the first insert -> queue empties immediately. One lcd_clear follows busy falling; records 2 and 3 are never inserted.
4. capture and clear_req in the same cycle, plus a second clear_req 2 cycles later -> count=0, overflow=0, exactly one lcd_clear pulse.
5. Bridge model never asserts busy after lcd_insert -> timeout_err=1 after 16 cycles; FSM back in IDLE; next queued record issued.
6. Full queue with capture coinciding with the pop cycle -> count stays 8, overflow stays 0, new record is emitted last. Assert reset mid-WAIT_FALL -> all outputs take their reset values the next cycle.
